// File: rtl/dsp_job_scheduler.sv
// Job scheduler for the shared FIR/FFT engines: round-robin intake from two requesters into a
// small job FIFO, then a dispatcher that runs engine start/done, output DMA and completion.
module dsp_job_scheduler #(
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req0,
    input  logic                           mode0,
    output logic                           ack0,
    input  logic                           req1,
    input  logic                           mode1,
    output logic                           ack1,
    output logic                           start_fir,
    output logic                           start_fft,
    input  logic                           fir_done,
    input  logic                           fft_done,
    output logic                           start_dma_out,
    input  logic                           dma_out_done,
    output logic                           job_src,
    output logic                           busy,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           timeout_err,
    input  logic                           err_clr,
    output logic [CNT_W-1:0]               jobs_done
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_ONE    = WD_W'(1);
    localparam logic [CNT_W-1:0] JOBS_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ENG,
        DMA,
        WAIT_DMA
    } state_t;

    state_t state_reg, state_next;

    // Each entry is {src, mode}
    logic [1:0]       fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic             ack0_reg, ack1_reg;
    logic             rr_reg;
    logic             src_reg, mode_reg;
    logic             fir_done_reg, fft_done_reg;
    logic [WD_W-1:0]  wdog_reg;
    logic             err_reg;
    logic [CNT_W-1:0] jobs_reg;

    logic elig0, elig1, push, pop, grant_src, grant_mode;
    logic done_match, set_err, job_ok;

    // A requester still holding req during its ack cycle is not eligible again
    always_comb begin
        elig0      = req0 && !ack0_reg;
        elig1      = req1 && !ack1_reg;
        push       = (count_reg < DEPTH_C) && (elig0 || elig1);
        grant_src  = (elig0 && elig1) ? rr_reg : elig1;
        grant_mode = grant_src ? mode1 : mode0;
        pop        = (state_reg == IDLE) && (count_reg != '0);
    end

    // Done pulses pass through a register, so DMA starts two cycles after the done pulse
    assign done_match = mode_reg ? fft_done_reg : fir_done_reg;

    always_comb begin
        state_next = state_reg;
        set_err    = 1'b0;
        job_ok     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pop) state_next = LAUNCH;
            end
            LAUNCH: begin
                state_next = WAIT_ENG;
            end
            WAIT_ENG: begin
                if (done_match) begin
                    state_next = DMA;
                end else if (wdog_reg == WD_LAST) begin
                    state_next = IDLE;
                    set_err    = 1'b1;
                end
            end
            DMA: begin
                state_next = WAIT_DMA;
            end
            WAIT_DMA: begin
                if (dma_out_done) begin
                    state_next = IDLE;
                    job_ok     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ack0_reg     <= 1'b0;
            ack1_reg     <= 1'b0;
            rr_reg       <= 1'b0;
            src_reg      <= 1'b0;
            mode_reg     <= 1'b0;
            fir_done_reg <= 1'b0;
            fft_done_reg <= 1'b0;
            wdog_reg     <= '0;
            err_reg      <= 1'b0;
            jobs_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            ack0_reg     <= push && !grant_src;
            ack1_reg     <= push && grant_src;
            fir_done_reg <= fir_done;
            fft_done_reg <= fft_done;

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                rr_reg     <= !grant_src;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                src_reg    <= fifo_mem[rd_ptr_reg][1];
                mode_reg   <= fifo_mem[rd_ptr_reg][0];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + COUNT_ONE;
                2'b01:   count_reg <= count_reg - COUNT_ONE;
                default: count_reg <= count_reg;
            endcase

            if (state_reg == WAIT_ENG) wdog_reg <= wdog_reg + WD_ONE;
            else                       wdog_reg <= '0;

            if (set_err)      err_reg <= 1'b1;
            else if (err_clr) err_reg <= 1'b0;

            if (job_ok) jobs_reg <= jobs_reg + JOBS_ONE;
        end
    end

    // Storage carries no reset so it can map onto plain memory; count and pointers define validity
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= {grant_src, grant_mode};
    end

    assign ack0          = ack0_reg;
    assign ack1          = ack1_reg;
    assign start_fir     = (state_reg == LAUNCH) && !mode_reg;
    assign start_fft     = (state_reg == LAUNCH) && mode_reg;
    assign start_dma_out = (state_reg == DMA);
    assign busy          = (state_reg != IDLE);
    assign job_src       = src_reg;
    assign queue_count   = count_reg;
    assign timeout_err   = err_reg;
    assign jobs_done     = jobs_reg;

endmodule

// File: tb/tb_dsp_job_scheduler.sv
// Directed bench for dsp_job_scheduler: reset, single job, contention, full queue,
// wrong-done filtering, engine timeout and mid-job reset, all with hand-derived expectations.
module tb_dsp_job_scheduler;
    localparam int QUEUE_DEPTH    = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int CNT_W          = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0 = 1'b0, mode0 = 1'b0, req1 = 1'b0, mode1 = 1'b0;
    logic fir_done = 1'b0, fft_done = 1'b0, dma_out_done = 1'b0, err_clr = 1'b0;
    logic ack0, ack1, start_fir, start_fft, start_dma_out, job_src, busy, timeout_err;
    logic [2:0]       queue_count;
    logic [CNT_W-1:0] jobs_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dsp_job_scheduler #(
        .QUEUE_DEPTH   (QUEUE_DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .mode0        (mode0),
        .ack0         (ack0),
        .req1         (req1),
        .mode1        (mode1),
        .ack1         (ack1),
        .start_fir    (start_fir),
        .start_fft    (start_fft),
        .fir_done     (fir_done),
        .fft_done     (fft_done),
        .start_dma_out(start_dma_out),
        .dma_out_done (dma_out_done),
        .job_src      (job_src),
        .busy         (busy),
        .queue_count  (queue_count),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr),
        .jobs_done    (jobs_done)
    );

    task automatic do_reset();
        reset = 1'b0;
        req0 = 1'b0; mode0 = 1'b0; req1 = 1'b0; mode1 = 1'b0;
        fir_done = 1'b0; fft_done = 1'b0; dma_out_done = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Raise a request, wait (bounded) for its ack, drop the request in the ack cycle
    task automatic do_req(input bit src, input bit mode, output bit acked);
        acked = 1'b0;
        if (src) begin req1 = 1'b1; mode1 = mode; end
        else     begin req0 = 1'b1; mode0 = mode; end
        for (int i = 0; i < 20 && !acked; i++) begin
            @(negedge clk);
            if ((src ? ack1 : ack0) === 1'b1) acked = 1'b1;
        end
        if (src) req1 = 1'b0;
        else     req0 = 1'b0;
    endtask

    // Called while in WAIT_ENG: pulse the engine done, wait for the DMA start, then finish the DMA
    task automatic complete_job(input bit fft, output bit ok);
        ok = 1'b0;
        if (fft) fft_done = 1'b1;
        else     fir_done = 1'b1;
        @(negedge clk);
        fir_done = 1'b0;
        fft_done = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (start_dma_out === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            @(negedge clk);
            dma_out_done = 1'b1;
            @(negedge clk);
            dma_out_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({ack0, ack1, start_fir, start_fft, start_dma_out, job_src, busy, timeout_err} !== 8'h00)
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {ack0, ack1, start_fir, start_fft, start_dma_out, job_src, busy, timeout_err});
        else pass_cnt++;
        total_cnt++;
        if (queue_count !== 3'd0) $display("FAIL reset_queue_count: got %0d expected 0", queue_count);
        else pass_cnt++;
        total_cnt++;
        if (jobs_done !== 16'd0) $display("FAIL reset_jobs_done: got %0d expected 0", jobs_done);
        else pass_cnt++;
        reset = 1'b1;
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_single_fir();
        do_reset();
        req0 = 1'b1; mode0 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ack0 !== 1'b1) $display("FAIL single_ack0: got %b expected 1", ack0);
        else pass_cnt++;
        total_cnt++;
        if (queue_count !== 3'd1) $display("FAIL single_count_push: got %0d expected 1", queue_count);
        else pass_cnt++;
        req0 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({start_fir, start_fft} !== 2'b10) $display("FAIL single_start: got %b expected 10", {start_fir, start_fft});
        else pass_cnt++;
        total_cnt++;
        if ({job_src, busy, ack0} !== 3'b010) $display("FAIL single_src_busy_ack: got %b expected 010", {job_src, busy, ack0});
        else pass_cnt++;
        total_cnt++;
        if (queue_count !== 3'd0) $display("FAIL single_count_pop: got %0d expected 0", queue_count);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (start_fir !== 1'b0) $display("FAIL single_start_pulse_width: got %b expected 0", start_fir);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        fir_done = 1'b1;
        @(negedge clk);
        fir_done = 1'b0;
        total_cnt++;
        if (start_dma_out !== 1'b0) $display("FAIL single_dma_early: got %b expected 0", start_dma_out);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (start_dma_out !== 1'b1) $display("FAIL single_dma_start: got %b expected 1", start_dma_out);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({start_dma_out, busy} !== 2'b01) $display("FAIL single_wait_dma: got %b expected 01", {start_dma_out, busy});
        else pass_cnt++;
        dma_out_done = 1'b1;
        @(negedge clk);
        dma_out_done = 1'b0;
        total_cnt++;
        if (jobs_done !== 16'd1) $display("FAIL single_jobs_done: got %0d expected 1", jobs_done);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b expected 0", busy);
        else pass_cnt++;
        $display("test_single_fir: FIR job from requester 0 completed, jobs_done=%0d", jobs_done);
    endtask

    task automatic test_contention();
        bit ok;
        do_reset();
        req0 = 1'b1; mode0 = 1'b0; req1 = 1'b1; mode1 = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({ack0, ack1} !== 2'b10) $display("FAIL cont_first_ack: got %b expected 10", {ack0, ack1});
        else pass_cnt++;
        req0 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({ack0, ack1} !== 2'b01) $display("FAIL cont_second_ack: got %b expected 01", {ack0, ack1});
        else pass_cnt++;
        total_cnt++;
        if ({start_fir, start_fft, job_src} !== 3'b100) $display("FAIL cont_fir_start: got %b expected 100", {start_fir, start_fft, job_src});
        else pass_cnt++;
        total_cnt++;
        if (queue_count !== 3'd1) $display("FAIL cont_count_push_pop: got %0d expected 1", queue_count);
        else pass_cnt++;
        req1 = 1'b0;
        @(negedge clk);
        complete_job(1'b0, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL cont_fir_dma: got dma_seen=%b expected 1", ok);
        else pass_cnt++;
        total_cnt++;
        if ({busy, start_fft} !== 2'b00) $display("FAIL cont_idle_gap: got %b expected 00", {busy, start_fft});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({start_fir, start_fft, job_src} !== 3'b011) $display("FAIL cont_fft_start: got %b expected 011", {start_fir, start_fft, job_src});
        else pass_cnt++;
        @(negedge clk);
        complete_job(1'b1, ok);
        total_cnt++;
        if ({ok, busy, jobs_done} !== {1'b1, 1'b0, 16'd2})
            $display("FAIL cont_done: got ok=%b busy=%b jobs=%0d expected ok=1 busy=0 jobs=2", ok, busy, jobs_done);
        else pass_cnt++;
        $display("test_contention: FIR(src0) then FFT(src1), jobs_done=%0d", jobs_done);
    endtask

    task automatic test_full_queue();
        bit acked, all_acked, seen, ok;
        all_acked = 1'b1;
        do_reset();
        do_req(1'b0, 1'b0, acked); all_acked &= acked;
        do_req(1'b1, 1'b1, acked); all_acked &= acked;
        do_req(1'b0, 1'b0, acked); all_acked &= acked;
        do_req(1'b1, 1'b1, acked); all_acked &= acked;
        do_req(1'b0, 1'b0, acked); all_acked &= acked;
        total_cnt++;
        if (all_acked !== 1'b1) $display("FAIL full_first_five_acked: got %b expected 1", all_acked);
        else pass_cnt++;
        total_cnt++;
        if ({queue_count, busy} !== {3'd4, 1'b1}) $display("FAIL full_count: got count=%0d busy=%b expected 4/1", queue_count, busy);
        else pass_cnt++;
        req1 = 1'b1; mode1 = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack1 !== 1'b0) seen = 1'b1;
        end
        total_cnt++;
        if ({seen, queue_count} !== {1'b0, 3'd4}) $display("FAIL full_no_ack: got ack_seen=%b count=%0d expected 0/4", seen, queue_count);
        else pass_cnt++;
        complete_job(1'b0, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL full_job_dma: got dma_seen=%b expected 1", ok);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({queue_count, ack1} !== {3'd3, 1'b0}) $display("FAIL full_pop_no_bypass: got count=%0d ack1=%b expected 3/0", queue_count, ack1);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({queue_count, ack1} !== {3'd4, 1'b1}) $display("FAIL full_late_ack: got count=%0d ack1=%b expected 4/1", queue_count, ack1);
        else pass_cnt++;
        req1 = 1'b0;
        $display("test_full_queue: sixth request accepted after pop, queue_count=%0d", queue_count);
    endtask

    task automatic test_wrong_done();
        bit acked, seen, ok;
        do_reset();
        do_req(1'b1, 1'b1, acked);
        @(negedge clk);
        total_cnt++;
        if ({acked, start_fir, start_fft, job_src} !== 4'b1011) $display("FAIL wrong_fft_start: got %b expected 1011", {acked, start_fir, start_fft, job_src});
        else pass_cnt++;
        @(negedge clk);
        fir_done = 1'b1;
        @(negedge clk);
        fir_done = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            if (start_dma_out !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if ({seen, busy} !== 2'b01) $display("FAIL wrong_done_ignored: got dma_seen=%b busy=%b expected 0/1", seen, busy);
        else pass_cnt++;
        complete_job(1'b1, ok);
        total_cnt++;
        if ({ok, jobs_done} !== {1'b1, 16'd1}) $display("FAIL wrong_fft_completes: got ok=%b jobs=%0d expected 1/1", ok, jobs_done);
        else pass_cnt++;
        $display("test_wrong_done: fir_done ignored on FFT job, jobs_done=%0d", jobs_done);
    endtask

    task automatic test_timeout();
        bit bad, ok;
        do_reset();
        req0 = 1'b1; mode0 = 1'b0; req1 = 1'b1; mode1 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        req1 = 1'b0;
        total_cnt++;
        if (start_fir !== 1'b1) $display("FAIL to_fir_start: got %b expected 1", start_fir);
        else pass_cnt++;
        bad = 1'b0;
        repeat (TIMEOUT_CYCLES) begin
            @(negedge clk);
            if (timeout_err !== 1'b0 || busy !== 1'b1 || start_dma_out !== 1'b0) bad = 1'b1;
        end
        total_cnt++;
        if (bad !== 1'b0) $display("FAIL to_early_abort: got early_event=%b expected 0", bad);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({timeout_err, busy} !== 2'b10) $display("FAIL to_abort: got err=%b busy=%b expected 1/0", timeout_err, busy);
        else pass_cnt++;
        total_cnt++;
        if (jobs_done !== 16'd0) $display("FAIL to_jobs_unchanged: got %0d expected 0", jobs_done);
        else pass_cnt++;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total_cnt++;
        if (timeout_err !== 1'b0) $display("FAIL to_err_clr: got %b expected 0", timeout_err);
        else pass_cnt++;
        total_cnt++;
        if ({start_fft, job_src} !== 2'b11) $display("FAIL to_next_dispatch: got %b expected 11", {start_fft, job_src});
        else pass_cnt++;
        @(negedge clk);
        complete_job(1'b1, ok);
        total_cnt++;
        if ({ok, jobs_done} !== {1'b1, 16'd1}) $display("FAIL to_next_completes: got ok=%b jobs=%0d expected 1/1", ok, jobs_done);
        else pass_cnt++;
        $display("test_timeout: FIR job aborted after %0d cycles, FFT job completed", TIMEOUT_CYCLES);
    endtask

    task automatic test_mid_reset();
        bit seen;
        do_reset();
        req0 = 1'b1; mode0 = 1'b0; req1 = 1'b1; mode1 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        req1 = 1'b0;
        req0 = 1'b1; mode0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        total_cnt++;
        if (queue_count !== 3'd2) $display("FAIL mid_two_queued: got %0d expected 2", queue_count);
        else pass_cnt++;
        fir_done = 1'b1;
        @(negedge clk);
        fir_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ({busy, start_dma_out} !== 2'b10) $display("FAIL mid_in_wait_dma: got %b expected 10", {busy, start_dma_out});
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({ack0, ack1, start_fir, start_fft, start_dma_out, job_src, busy, timeout_err, queue_count, jobs_done} !== 27'd0)
            $display("FAIL mid_reset_outputs: got outs=%b count=%0d jobs=%0d expected all 0",
                     {ack0, ack1, start_fir, start_fft, start_dma_out, job_src, busy, timeout_err}, queue_count, jobs_done);
        else pass_cnt++;
        reset = 1'b1;
        dma_out_done = 1'b1;
        @(negedge clk);
        dma_out_done = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            if (busy !== 1'b0 || start_fir !== 1'b0 || start_fft !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if ({seen, jobs_done} !== {1'b0, 16'd0}) $display("FAIL mid_stale_done_ignored: got activity=%b jobs=%0d expected 0/0", seen, jobs_done);
        else pass_cnt++;
        $display("test_mid_reset: queue flushed, stale dma_out_done ignored");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        test_reset();
        test_single_fir();
        test_contention();
        test_full_queue();
        test_wrong_done();
        test_timeout();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dsp_job_scheduler.md
Name: dsp_job_scheduler

Overview:
- Queues FIR/FFT processing jobs from two input requesters (e.g. two DMA-in channels) and dispatches them one at a time to the shared FIR/FFT engines.
- After each job it triggers the output DMA.
- Round-robin arbitration feeds a small job FIFO. A dispatcher FSM sequences engine start, done, DMA-out and completion.
- Engine hangs are caught with a watchdog timeout.

Parameters:
- QUEUE_DEPTH, 4, job FIFO entries; power of 2, >=2.
- TIMEOUT_CYCLES, 1024, max cycles in WAIT_ENG before abort; >=2.
- CNT_W, 16, width of jobs_done counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req0  in  1  requester 0 job request; level, held until ack0
- mode0  in  1  requester 0 job type: 0=FIR, 1=FFT
- ack0  out  1  one-cycle accept pulse to requester 0
- req1  in  1  requester 1 job request
- mode1  in  1  requester 1 job type
- ack1  out  1  one-cycle accept pulse to requester 1
- start_fir  out  1  one-cycle FIR engine start pulse
- start_fft  out  1  one-cycle FFT engine start pulse
- fir_done  in  1  FIR completion pulse
- fft_done  in  1  FFT completion pulse
- start_dma_out  out  1  one-cycle output-DMA start pulse
- dma_out_done  in  1  output-DMA completion pulse
- job_src  out  1  requester index of the job being serviced (valid while busy)
- busy  out  1  high when FSM not in IDLE
- queue_count  out  log2(QUEUE_DEPTH)+1  FIFO occupancy
- timeout_err  out  1  sticky engine-timeout flag
- err_clr  in  1  clears timeout_err
- jobs_done  out  CNT_W  completed-job counter; wraps modulo 2^CNT_W

Behaviour:
- Reset (reset==0 at rising edge):
  - All outputs 0. FSM to IDLE, FIFO flushed (count 0), RR pointer to requester 0, watchdog 0.
  - Applies mid-job too. Pulses drop the cycle after the reset edge.
  - Done inputs arriving after reset are ignored.
- Arbitration (every cycle):
  - Eligible requester: req high AND its ack not high this cycle. The requester drops req the cycle after ack; a req still high during the ack cycle is not double-counted.
  - If queue_count < QUEUE_DEPTH and one requester is eligible, push {src, mode} and pulse its ack on the next cycle.
  - If both are eligible, grant the RR-pointer requester. The pointer moves to the other requester after every grant.
  - FIFO full: no push, no ack; requests wait. Push is decided on pre-pop count; no same-cycle full bypass.
- Dispatcher FSM:
  - IDLE: if queue_count>0, pop head, latch src/mode -> LAUNCH.
  - LAUNCH (1 cycle): start_fir=1 if mode=0, else start_fft=1 -> WAIT_ENG. Watchdog cleared.
  - WAIT_ENG:
    - Done matching the latched mode -> DMA.
    - The non-matching done is ignored.
    - Watchdog increments each cycle. If it reaches TIMEOUT_CYCLES without done: set timeout_err, discard the job (no DMA, no count) -> IDLE.
  - DMA (1 cycle): start_dma_out=1 -> WAIT_DMA.
  - WAIT_DMA: on dma_out_done, jobs_done+1 -> IDLE. No timeout here.
- Latency:
  - req sampled at edge k gives ack high after edge k.
  - Pop at edge k+1; start_* high after edge k+1, i.e. start is 1 cycle after ack.
  - done sampled at edge m gives start_dma_out high after m+1 (in DMA state).
  - Back-to-back jobs: at least 1 IDLE cycle between dma_out_done and the next start_*.
- Simultaneous push and pop: queue_count unchanged.
- FIFO pointers wrap modulo QUEUE_DEPTH.
- timeout_err: set has priority over err_clr in the same cycle; otherwise err_clr clears it.
- job_src holds its last value when idle.

Test Plan:
- Single FIR: reset low for 2 cycles, then req0=1 mode0=0 -> ack0 at cycle c, start_fir at c+1; fir_done 5 cycles later -> start_dma_out 2 cycles after fir_done; dma_out_done -> jobs_done=1, busy=0.
- Contention: req0 and req1 both high in the same cycle (mode0=0, mode1=1) -> ack0 first, ack1 next cycle; FIR dispatched with job_src=0, then FFT with job_src=1; jobs_done=2.
- Full queue: hold engine busy, issue 6 alternating requests with DEPTH=4 -> queue_count reaches 4 (plus 1 in service); 6th req has no ack until a pop, then ack.
- Wrong done: FFT job active, pulse fir_done -> no start_dma_out; fft_done -> DMA starts.
- Timeout: TIMEOUT_CYCLES=16, no done -> timeout_err=1 after 16 WAIT_ENG cycles, FSM IDLE, jobs_done unchanged; err_clr -> timeout_err=0; next queued job dispatches.
- Mid-job reset: assert reset during WAIT_DMA with 2 jobs queued -> all outputs 0, queue_count=0, later dma_out_done ignored.
